// File: rtl/fire5_squeeze_ram_pkg.sv
// Shared constants and FSM state type for the fire5 squeeze activation buffer.
package fire5_pkg;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 32;
  localparam int WOUT   = 32;

  // Word-address width for a WOUT x WOUT x DSP_NO buffer.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W = addr_bits(WOUT * WOUT * DSP_NO);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fire5_squeeze_ram_if.sv
// Producer/consumer bus of the fire5 squeeze buffer: sample capture in, word stream out.
interface fire5_squeeze_ram_if #(
  parameter int WIDTH  = fire5_pkg::WIDTH,
  parameter int DSP_NO = fire5_pkg::DSP_NO
);

  logic             fire5_squeeze_sample;
  logic [WIDTH-1:0] ofm_in [0:DSP_NO-1];
  logic             ram_feedback;
  logic             fire5_expand_en;
  logic [WIDTH-1:0] expand_ifm;
  logic             expand_ifm_valid;
  logic             buffer_done;
  logic             overflow_err;

  modport master (
    output fire5_squeeze_sample, ofm_in, fire5_expand_en,
    input  ram_feedback, expand_ifm, expand_ifm_valid, buffer_done, overflow_err
  );

  modport slave (
    input  fire5_squeeze_sample, ofm_in, fire5_expand_en,
    output ram_feedback, expand_ifm, expand_ifm_valid, buffer_done, overflow_err
  );

endinterface

// File: rtl/fire5_squeeze_ram_sp_ram.sv
// Single-port activation memory: synchronous read, one-cycle latency, no reset.
module sp_ram_fire5_squeeze #(
  parameter int WIDTH = fire5_pkg::WIDTH,
  parameter int DEPTH = fire5_pkg::WOUT * fire5_pkg::WOUT * fire5_pkg::DSP_NO,
  parameter int AW    = fire5_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // One access per cycle: write has priority, otherwise an optional read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fire5_squeeze_ram.sv
// Fire5 squeeze buffer: captures per-pixel channel vectors, serializes them into
// memory, then streams every word out in address order.
module fire5_squeeze_ram #(
  parameter int WIDTH  = fire5_pkg::WIDTH,
  parameter int DSP_NO = fire5_pkg::DSP_NO,
  parameter int WOUT   = fire5_pkg::WOUT
) (
  input logic                clk,
  input logic                rst,
  fire5_squeeze_ram_if.slave bus
);

  import fire5_pkg::*;

  localparam int PIX_N = WOUT * WOUT;
  localparam int DEPTH = PIX_N * DSP_NO;
  localparam int AW    = addr_bits(DEPTH);
  localparam int CW    = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PW    = $clog2(PIX_N + 1);

  localparam logic [PW-1:0] PIX_FULL  = PW'(PIX_N);
  localparam logic [CW-1:0] CH_LAST   = CW'(DSP_NO - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_stage [0:DSP_NO-1];
  logic             r_busy;
  logic [CW-1:0]    r_ch;
  logic [PW-1:0]    r_pix;
  logic [AW-1:0]    r_rd_addr;
  logic             r_valid;
  logic             r_done;
  logic             r_ovf;

  logic             w_full;
  logic             w_capture;
  logic             w_rd_en;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_ram_addr;
  logic [WIDTH-1:0] w_ram_q;

  assign w_full     = (r_pix == PIX_FULL);
  assign w_capture  = bus.fire5_squeeze_sample && !r_busy && !w_full;
  assign w_rd_en    = (r_state == S_READ) && bus.fire5_expand_en;
  assign w_wr_addr  = AW'(r_pix) * AW'(DSP_NO) + AW'(r_ch);
  // Reads only happen in S_READ, which is entered with the serializer idle.
  assign w_ram_addr = r_busy ? w_wr_addr : r_rd_addr;

  // Staging registers take the whole channel vector on an accepted sample.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int unsigned c = 0; c < DSP_NO; c++) begin
        r_stage[c] <= bus.ofm_in[c];
      end
    end
  end

  // Serializer: one staged word per cycle, then advance the pixel count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_ch   <= '0;
      r_pix  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (bus.fire5_squeeze_sample && r_busy) begin
        r_ovf <= 1'b1;
      end
      if (w_capture) begin
        r_busy <= 1'b1;
        r_ch   <= '0;
      end else if (r_busy) begin
        if (r_ch == CH_LAST) begin
          r_busy <= 1'b0;
          r_ch   <= '0;
          r_pix  <= r_pix + 1'b1;
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end
    end
  end

  // Fill/read/done sequencing with registered read-valid and done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FILL;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      // Done follows residence in S_DONE, so it rises after the last valid word.
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_FILL: begin
          if (w_full && !r_busy) r_state <= S_READ;
        end
        S_READ: begin
          if (bus.fire5_expand_en) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            if (r_rd_addr == ADDR_LAST) r_state <= S_DONE;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  sp_ram_fire5_squeeze #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_busy),
    .i_re    (w_rd_en),
    .i_addr  (w_ram_addr),
    .i_wdata (r_stage[r_ch]),
    .o_rdata (w_ram_q)
  );

  assign bus.ram_feedback     = r_busy;
  assign bus.expand_ifm_valid = r_valid;
  assign bus.expand_ifm       = r_valid ? w_ram_q : '0;
  assign bus.buffer_done      = r_done;
  assign bus.overflow_err     = r_ovf;

endmodule

// File: tb/tb_fire5_squeeze_ram.sv
// Directed/random bench for fire5_squeeze_ram with a reduced 4x4 feature map.
module tb_fire5_squeeze_ram;

  localparam int W    = 16;
  localparam int D    = 32;
  localparam int WO   = 4;
  localparam int NPIX = WO * WO;
  localparam int NW   = NPIX * D;
  localparam int GAP  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fire5_squeeze_ram_if #(.WIDTH(W), .DSP_NO(D)) bus ();

  fire5_squeeze_ram #(.WIDTH(W), .DSP_NO(D), .WOUT(WO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int bad_valid;
  int exp_addr;
  int rf_cnt;
  int last_valid_step;
  int done_step;
  int tog_seq [6] = '{1, 0, 0, 1, 0, 0};
  logic [W-1:0] ref_mem [NW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf"},    32'(bus.ram_feedback),     0);
    check({tag, "_valid"}, 32'(bus.expand_ifm_valid), 0);
    check({tag, "_done"},  32'(bus.buffer_done),      0);
    check({tag, "_ovf"},   32'(bus.overflow_err),     0);
    check({tag, "_ifm"},   32'(bus.expand_ifm),       0);
  endtask

  // Random vector for one pixel; optional duplicate sample while the serializer is busy.
  task automatic send_sample(input int pix, input bit dup);
    logic [W-1:0] v;
    for (int c = 0; c < D; c++) begin
      v = W'($urandom);
      bus.ofm_in[c] = v;
      ref_mem[pix * D + c] = v;
    end
    bus.fire5_squeeze_sample = 1'b1;
    step();
    bus.fire5_squeeze_sample = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      if (dup && g == 5) begin
        for (int c = 0; c < D; c++) bus.ofm_in[c] = ~ref_mem[pix * D + c];
        bus.fire5_squeeze_sample = 1'b1;
      end
      if (dup && g == 6) bus.fire5_squeeze_sample = 1'b0;
      step();
      if (bus.expand_ifm_valid) bad_valid++;
    end
  endtask

  // Fill pixels first..NPIX-1; read enable optionally held high except for the last pixel.
  task automatic fill(input int first, input bit en_hold, input int dup_pix);
    bad_valid = 0;
    for (int p = first; p < NPIX; p++) begin
      bus.fire5_expand_en = en_hold && (p != NPIX - 1);
      send_sample(p, p == dup_pix);
    end
    check("fill_no_valid", 32'(bad_valid), 0);
    check("fill_rf_idle", 32'(bus.ram_feedback), 0);
  endtask

  // Hold enable high from the current address to the end and check ordering and done timing.
  task automatic stream_rest(input string tag);
    bus.fire5_expand_en = 1'b1;
    last_valid_step = -1;
    done_step = -1;
    for (int s = 0; s < NW + 20 && done_step < 0; s++) begin
      step();
      if (bus.expand_ifm_valid) begin
        check({tag, "_data"}, 32'(bus.expand_ifm), 32'(ref_mem[exp_addr % NW]));
        exp_addr++;
        last_valid_step = s;
      end
      if (bus.buffer_done && done_step < 0) done_step = s;
    end
    check({tag, "_count"}, 32'(exp_addr), NW);
    check({tag, "_done_timing"}, 32'(done_step), 32'(last_valid_step + 1));
    for (int s = 0; s < 5; s++) begin
      step();
      check({tag, "_done_no_valid"}, 32'(bus.expand_ifm_valid), 0);
      check({tag, "_done_held"}, 32'(bus.buffer_done), 1);
    end
  endtask

  initial begin
    bus.fire5_squeeze_sample = 1'b0;
    bus.fire5_expand_en = 1'b0;
    for (int c = 0; c < D; c++) bus.ofm_in[c] = '0;
    #2 rst = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Pixel 0 carries 1..32; a second sample 10 cycles later must be dropped.
    for (int c = 0; c < D; c++) begin
      bus.ofm_in[c] = W'(c + 1);
      ref_mem[c] = W'(c + 1);
    end
    check("rf_before_capture", 32'(bus.ram_feedback), 0);
    bus.fire5_squeeze_sample = 1'b1;
    rf_cnt = 0;
    for (int i = 0; i < GAP; i++) begin
      step();
      if (i == 0) begin
        bus.fire5_squeeze_sample = 1'b0;
        check("rf_first_cycle", 32'(bus.ram_feedback), 1);
        check("ovf_clear", 32'(bus.overflow_err), 0);
      end
      if (i == 9) begin
        for (int c = 0; c < D; c++) bus.ofm_in[c] = W'(16'hA500 + c);
        bus.fire5_squeeze_sample = 1'b1;
      end
      if (i == 10) bus.fire5_squeeze_sample = 1'b0;
      if (bus.ram_feedback) rf_cnt++;
    end
    check("rf_cycles", 32'(rf_cnt), 32);
    check("ovf_set", 32'(bus.overflow_err), 1);

    // Remaining pixels with read enable held high while filling.
    fill(1, 1'b1, -1);
    repeat (5) step();
    check("read_stall_valid", 32'(bus.expand_ifm_valid), 0);
    check("read_stall_done", 32'(bus.buffer_done), 0);
    check("ovf_sticky", 32'(bus.overflow_err), 1);

    // Enable pattern 1,0,0,1: two words at consecutive addresses.
    exp_addr = 0;
    for (int k = 0; k < 6; k++) begin
      bus.fire5_expand_en = (tog_seq[k] != 0);
      step();
      check("tog_valid", 32'(bus.expand_ifm_valid), 32'(tog_seq[k]));
      if (tog_seq[k] != 0) begin
        check("tog_data", 32'(bus.expand_ifm), 32'(ref_mem[exp_addr]));
        exp_addr++;
      end
    end
    stream_rest("read1");

    // Refill with random data and an overflow mid-fill, then reset at read address 500.
    rst = 1'b0;
    #1;
    check_reset_outputs("reset2");
    rst = 1'b1;
    fill(0, 1'b1, 3);
    check("ovf_fill2", 32'(bus.overflow_err), 1);
    bus.fire5_expand_en = 1'b1;
    exp_addr = 0;
    for (int s = 0; s < NW && exp_addr < 500; s++) begin
      step();
      if (bus.expand_ifm_valid) begin
        check("read2_data", 32'(bus.expand_ifm), 32'(ref_mem[exp_addr]));
        exp_addr++;
      end
    end
    check("read2_reach500", 32'(exp_addr), 500);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("reset_midread");
    #2 rst = 1'b1;

    // After reset the full pixel count is needed again before reads resume at address 0.
    fill(0, 1'b1, -1);
    check("ovf_fill3", 32'(bus.overflow_err), 0);
    exp_addr = 0;
    stream_rest("read3");

    // A sample arriving with the buffer full is ignored without raising an error.
    for (int c = 0; c < D; c++) bus.ofm_in[c] = W'($urandom);
    bus.fire5_squeeze_sample = 1'b1;
    step();
    bus.fire5_squeeze_sample = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("full_sample_rf", 32'(bus.ram_feedback), 0);
    end
    check("full_sample_ovf", 32'(bus.overflow_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fire5_squeeze_ram.md
FIRE5_SQUEEZE_RAM -- requirements
Module: fire5_squeeze_ram

Interface
REQ-001 Parameter WIDTH, default 16, activation word width.
REQ-002 Parameter DSP_NO, default 32, channels produced per sample.
REQ-003 Parameter WOUT, default 32, feature-map side; pixel count is WOUT**2.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 fire5_squeeze_sample  in  1  one-cycle pulse; ofm_in is valid in the same cycle.
REQ-007 ofm_in  in  WIDTH x DSP_NO (unpacked [0:DSP_NO-1])  one pixel's channel vector.
REQ-008 ram_feedback  out  1  high while captured words are still being written to memory.
REQ-009 fire5_expand_en  in  1  downstream read enable; one word per cycle while high.
REQ-010 expand_ifm  out  WIDTH  streamed activation word.
REQ-011 expand_ifm_valid  out  1  expand_ifm is valid this cycle.
REQ-012 buffer_done  out  1  all words have been streamed; stays high until reset.
REQ-013 overflow_err  out  1  sticky flag: a sample arrived while the serializer was busy.

Function
REQ-014 Memory: WOUT**2*DSP_NO words of WIDTH bits; word address = pixel*DSP_NO + channel; 15-bit address at defaults.
REQ-015 Capture: on fire5_squeeze_sample with the serializer idle, latch all DSP_NO words of ofm_in into staging registers and start the serializer in the next cycle.
REQ-016 Serializer: writes staging word ch at pixel_cnt*DSP_NO+ch, one word per cycle, ch = 0..DSP_NO-1, over DSP_NO cycles, then increments pixel_cnt and goes idle.
REQ-017 ram_feedback: high from the cycle after capture through the cycle of the last serializer write, inclusive; low otherwise.
REQ-018 Sample arriving while the serializer is busy: ignored (no capture, no write); overflow_err set and held.
REQ-019 Samples arriving when pixel_cnt == WOUT**2: ignored; no error raised.
REQ-020 FSM states: S_FILL (reset state), S_READ, S_DONE.
REQ-021 S_FILL -> S_READ when pixel_cnt == WOUT**2 and the serializer is idle.
REQ-022 S_READ: each cycle fire5_expand_en is high, issue a read at rd_addr and increment rd_addr; fire5_expand_en low stalls, with rd_addr held.
REQ-023 Read latency is 1 cycle: expand_ifm_valid is high the cycle after each issued read, and expand_ifm holds the word at that address.
REQ-024 S_READ -> S_DONE in the cycle the read of address WOUT**2*DSP_NO-1 is issued; buffer_done is high from the following cycle.
REQ-025 S_DONE: no reads issued; fire5_expand_en ignored; expand_ifm_valid low.
REQ-026 fire5_expand_en asserted in S_FILL: ignored; no reads issued.
REQ-027 Write and read never share a cycle, so a single-port memory is sufficient.
REQ-028 Data is stored unmodified; no arithmetic is performed on activation words.

Reset
REQ-029 Asynchronous assertion of rst returns the block to S_FILL, including mid-fill or mid-read: pixel_cnt=0, rd_addr=0, serializer idle, ram_feedback=0, expand_ifm_valid=0, buffer_done=0, overflow_err=0, expand_ifm=0.
REQ-030 Memory contents are not reset, and staging registers need no reset.

Structure
REQ-031 Shared package fire5_pkg holds WIDTH, DSP_NO, WOUT, the address-width localparam, and the FSM state enum typedef.
REQ-032 The memory is one sub-module, sp_ram_fire5_squeeze: single port, synchronous read, 1-cycle latency, inferable as block RAM.

Verification
REQ-033 A sample with ofm_in[ch]=ch+1 at pixel 0: ram_feedback high for exactly 32 cycles starting the cycle after the sample; words 0..31 read back as 1..32.
REQ-034 Full fill of 1024 samples spaced 257 cycles apart, then fire5_expand_en held high: 32768 valid words in address order; buffer_done rises the cycle after the last valid word.
REQ-035 Second sample 10 cycles after the first: overflow_err=1 and the second vector is absent from memory; the first vector is intact.
REQ-036 In S_READ, fire5_expand_en toggled 1,0,0,1: exactly 2 valid words at consecutive addresses, each 1 cycle after its enable.
REQ-037 rst pulsed low at read address 500: all outputs take their reset values immediately; the FSM is in S_FILL and returns to S_READ only after 1024 new samples.
REQ-038 fire5_expand_en held high during S_FILL: expand_ifm_valid stays 0 and rd_addr stays 0.
